// File: rtl/sd_pkg.sv
// Shared types and constants for the SPI-mode SD card responder.
package sd_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CMD_RX,
        ST_RESP_GAP,
        ST_RESP_TX,
        ST_WR_WAIT_TOKEN,
        ST_WR_DATA_RX,
        ST_DRESP_GAP,
        ST_DRESP_TX,
        ST_WR_BUSY,
        ST_RD_GAP,
        ST_RD_TX
    } sd_state_e;

    localparam logic [5:0]  CMD_READ    = 6'd17;
    localparam logic [5:0]  CMD_WRITE   = 6'd24;
    localparam logic [7:0]  TOKEN_START = 8'hFE;
    localparam logic [7:0]  DRESP_OK    = 8'h05;
    localparam logic [7:0]  DRESP_CRC   = 8'h0B;

    localparam logic [7:0]  R1_OK       = 8'h00;
    localparam logic [7:0]  R1_FRAME    = 8'h01;
    localparam logic [7:0]  R1_ILLEGAL  = 8'h04;
    localparam logic [7:0]  R1_CRC      = 8'h08;
    localparam logic [7:0]  R1_ADDR     = 8'h40;

    localparam logic [6:0]  POLY7       = 7'h09;
    localparam logic [15:0] POLY16      = 16'h1021;

    localparam int unsigned CNT_W       = 16;
    localparam int unsigned CMD_BITS    = 48;
    localparam int unsigned CRC7_ZONE   = 40;
    localparam int unsigned DATA_BITS   = 64;
    localparam int unsigned TOKEN_BITS  = 8;
    localparam int unsigned WR_BITS     = 80;
    localparam int unsigned RD_BITS     = 88;

endpackage

// File: rtl/sd_crc_serial.sv
// Bit-serial MSB-first CRC LFSR with synchronous clear; clear and enable together
// restart the CRC with the current bit as the first one.
module sd_crc_serial #(
    parameter int unsigned      W    = 7,
    parameter logic [W-1:0]     POLY = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic         din_i,
    output logic [W-1:0] crc_o
);

    logic [W-1:0] crc_q;
    logic [W-1:0] crc_d;
    logic [W-1:0] base;

    always_comb begin
        base  = clr_i ? '0 : crc_q;
        crc_d = base;
        if (en_i) begin
            crc_d = {base[W-2:0], 1'b0} ^ ((din_i ^ base[W-1]) ? POLY : '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/sd_card_responder.sv
// Card side of the SPI-mode SD link: decodes CMD17/CMD24, returns R1 and moves one
// 64-bit block with CRC16 between MOSI/MISO and an internal block memory.
module sd_card_responder
    import sd_pkg::*;
#(
    parameter int unsigned ADDR_W   = 6,
    parameter int unsigned RESP_DLY = 1,
    parameter int unsigned DATA_DLY = 1,
    parameter int unsigned BUSY_CYC = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              MOSI,
    output logic              MISO,
    input  logic              bd_we,
    input  logic [ADDR_W-1:0] bd_addr,
    input  logic [63:0]       bd_wdata,
    output logic [63:0]       bd_rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    sd_state_e           state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
    logic [CMD_BITS-2:0] cmd_sh_q, cmd_sh_d;
    logic [7:0]          byte_q, byte_d;
    logic                is_wr_q, is_wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [63:0]         data_q, data_d;
    logic [15:0]         rxcrc_q, rxcrc_d;
    logic                miso_q, miso_d;

    logic [63:0]         mem_q [DEPTH];
    logic                mem_we_c;

    logic                crc7_clr_c, crc7_en_c;
    logic                crc16_clr_c, crc16_en_c, crc16_din_c;
    logic [6:0]          crc7_w;
    logic [15:0]         crc16_w;

    logic [CMD_BITS-1:0] frame_c;
    logic [5:0]          cmd_c;
    logic [31:0]         arg_c;
    logic [ADDR_W-1:0]   addr_c;
    logic [7:0]          r1_c;

    sd_crc_serial #(.W(7), .POLY(POLY7)) u_crc7 (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (crc7_clr_c),
        .en_i  (crc7_en_c),
        .din_i (MOSI),
        .crc_o (crc7_w)
    );

    sd_crc_serial #(.W(16), .POLY(POLY16)) u_crc16 (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (crc16_clr_c),
        .en_i  (crc16_en_c),
        .din_i (crc16_din_c),
        .crc_o (crc16_w)
    );

    // Full frame as seen on the edge that samples the end bit.
    assign frame_c = {cmd_sh_q, MOSI};
    assign cmd_c   = frame_c[45:40];
    assign arg_c   = frame_c[39:8];
    assign addr_c  = arg_c[ADDR_W-1:0];

    // Later assignments carry the higher-priority error.
    always_comb begin
        r1_c = R1_OK;
        if ((arg_c >> ADDR_W) != 32'd0) r1_c = R1_ADDR;
        if (cmd_c != CMD_READ && cmd_c != CMD_WRITE) r1_c = R1_ILLEGAL;
        if (frame_c[7:1] != crc7_w) r1_c = R1_CRC;
        if (frame_c[47:46] != 2'b01 || !frame_c[0]) r1_c = R1_FRAME;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cmd_sh_d    = cmd_sh_q;
        byte_d      = byte_q;
        is_wr_d     = is_wr_q;
        addr_d      = addr_q;
        data_d      = data_q;
        rxcrc_d     = rxcrc_q;
        miso_d      = 1'b1;
        mem_we_c    = 1'b0;
        crc7_clr_c  = 1'b0;
        crc7_en_c   = 1'b0;
        crc16_clr_c = 1'b0;
        crc16_en_c  = 1'b0;
        crc16_din_c = MOSI;
        cnt_inc     = cnt_q + CNT_W'(1);

        unique case (state_q)
            ST_IDLE: begin
                crc7_clr_c = 1'b1;
                if (!MOSI) begin
                    crc7_en_c = 1'b1;
                    cmd_sh_d  = '0;
                    cnt_d     = CNT_W'(1);
                    state_d   = ST_CMD_RX;
                end
            end
            ST_CMD_RX: begin
                crc7_en_c = (cnt_q < CNT_W'(CRC7_ZONE));
                if (cnt_q == CNT_W'(CMD_BITS - 1)) begin
                    byte_d      = r1_c;
                    is_wr_d     = (cmd_c == CMD_WRITE);
                    addr_d      = addr_c;
                    crc16_clr_c = 1'b1;
                    cnt_d       = '0;
                    if (r1_c == R1_OK && cmd_c == CMD_READ) data_d = mem_q[addr_c];
                    state_d     = (RESP_DLY == 0) ? ST_RESP_TX : ST_RESP_GAP;
                end else begin
                    cmd_sh_d = {cmd_sh_q[CMD_BITS-3:0], MOSI};
                    cnt_d    = cnt_inc;
                end
            end
            ST_RESP_GAP: begin
                cnt_d = cnt_inc;
                if (cnt_q == CNT_W'(8 * RESP_DLY - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_RESP_TX;
                end
            end
            ST_RESP_TX: begin
                miso_d = byte_q[~cnt_q[2:0]];
                cnt_d  = cnt_inc;
                if (cnt_q == CNT_W'(7)) begin
                    cnt_d = '0;
                    if (byte_q != R1_OK)  state_d = ST_IDLE;
                    else if (is_wr_q)     state_d = ST_WR_WAIT_TOKEN;
                    else if (DATA_DLY == 0) state_d = ST_RD_TX;
                    else                  state_d = ST_RD_GAP;
                end
            end
            ST_WR_WAIT_TOKEN: begin
                if (!MOSI) begin
                    crc16_clr_c = 1'b1;
                    cnt_d       = '0;
                    state_d     = ST_WR_DATA_RX;
                end
            end
            ST_WR_DATA_RX: begin
                if (cnt_q < CNT_W'(DATA_BITS)) begin
                    crc16_en_c = 1'b1;
                    data_d     = {data_q[62:0], MOSI};
                end else begin
                    rxcrc_d = {rxcrc_q[14:0], MOSI};
                end
                cnt_d = cnt_inc;
                if (cnt_q == CNT_W'(WR_BITS - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_DRESP_GAP;
                end
            end
            ST_DRESP_GAP: begin
                // First gap cycle: received CRC is complete, commit or reject.
                if (cnt_q == '0) begin
                    if (rxcrc_q == crc16_w) begin
                        mem_we_c = 1'b1;
                        byte_d   = DRESP_OK;
                    end else begin
                        byte_d   = DRESP_CRC;
                    end
                end
                cnt_d = cnt_inc;
                if (cnt_q == CNT_W'(7)) begin
                    cnt_d   = '0;
                    state_d = ST_DRESP_TX;
                end
            end
            ST_DRESP_TX: begin
                miso_d = byte_q[~cnt_q[2:0]];
                cnt_d  = cnt_inc;
                if (cnt_q == CNT_W'(7)) begin
                    cnt_d   = '0;
                    state_d = (byte_q == DRESP_OK) ? ST_WR_BUSY : ST_IDLE;
                end
            end
            ST_WR_BUSY: begin
                miso_d = 1'b0;
                cnt_d  = cnt_inc;
                if (cnt_q == CNT_W'(BUSY_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            ST_RD_GAP: begin
                cnt_d = cnt_inc;
                if (cnt_q == CNT_W'(8 * DATA_DLY - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_RD_TX;
                end
            end
            ST_RD_TX: begin
                // Token, then data (fed into CRC16 as it leaves), then the CRC.
                if (cnt_q < CNT_W'(TOKEN_BITS)) begin
                    miso_d = TOKEN_START[~cnt_q[2:0]];
                end else if (cnt_q < CNT_W'(TOKEN_BITS + DATA_BITS)) begin
                    miso_d      = data_q[63];
                    data_d      = {data_q[62:0], 1'b0};
                    crc16_en_c  = 1'b1;
                    crc16_din_c = data_q[63];
                end else begin
                    miso_d = crc16_w[4'(CNT_W'(RD_BITS - 1) - cnt_q)];
                end
                cnt_d = cnt_inc;
                if (cnt_q == CNT_W'(RD_BITS - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            cmd_sh_q <= '0;
            byte_q   <= '0;
            is_wr_q  <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            rxcrc_q  <= '0;
            miso_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cmd_sh_q <= cmd_sh_d;
            byte_q   <= byte_d;
            is_wr_q  <= is_wr_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            rxcrc_q  <= rxcrc_d;
            miso_q   <= miso_d;
        end
    end

    // Block memory keeps its contents across reset; FSM write has priority.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem_q[addr_q] <= data_q;
        end else if (bd_we && state_q == ST_IDLE) begin
            mem_q[bd_addr] <= bd_wdata;
        end
    end

    assign bd_rdata = mem_q[bd_addr];
    assign MISO     = miso_q;

endmodule

// File: tb/tb_sd_card_responder.sv
// Scoreboard bench: stimulus queues expected MISO windows, a monitor collects and compares them.
module tb_sd_card_responder;

    localparam int unsigned ADDR_W   = 6;
    localparam int unsigned RESP_DLY = 1;
    localparam int unsigned DATA_DLY = 1;
    localparam int unsigned BUSY_CYC = 16;

    logic              clk      = 1'b0;
    logic              rst_n    = 1'b0;
    logic              MOSI     = 1'b1;
    logic              MISO;
    logic              bd_we    = 1'b0;
    logic [ADDR_W-1:0] bd_addr  = '0;
    logic [63:0]       bd_wdata = '0;
    logic [63:0]       bd_rdata;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int          cyc;
        int          nbits;
        logic [87:0] val;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    bit   mon_busy = 1'b0;

    sd_card_responder #(
        .ADDR_W   (ADDR_W),
        .RESP_DLY (RESP_DLY),
        .DATA_DLY (DATA_DLY),
        .BUSY_CYC (BUSY_CYC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .bd_we    (bd_we),
        .bd_addr  (bd_addr),
        .bd_wdata (bd_wdata),
        .bd_rdata (bd_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [6:0] crc7_of(input logic [39:0] v);
        logic [7:0] c;
        logic [7:0] b;
        c = 8'h00;
        for (int k = 4; k >= 0; k--) begin
            b = v[k*8 +: 8];
            for (int j = 0; j < 8; j++) begin
                c = {c[6:0], 1'b0};
                if (b[7] ^ c[7]) c = c ^ 8'h09;
                c[7] = 1'b0;
                b = {b[6:0], 1'b0};
            end
        end
        return c[6:0];
    endfunction

    function automatic logic [15:0] crc16_of(input logic [63:0] d);
        logic [15:0] c;
        c = 16'h0000;
        for (int k = 7; k >= 0; k--) begin
            c = c ^ {d[k*8 +: 8], 8'h00};
            for (int j = 0; j < 8; j++) begin
                c = c[15] ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
            end
        end
        return c;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic push(input int c, input int n, input logic [87:0] v, input string s);
        exp_t e;
        e.cyc   = c;
        e.nbits = n;
        e.val   = v;
        e.name  = s;
        exp_q.push_back(e);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Drives n bits MSB first; returns the cycle in which the last bit was driven.
    task automatic send_bits(input logic [87:0] v, input int n, output int last_c);
        for (int i = n - 1; i >= 0; i--) begin
            @(negedge clk);
            MOSI = v[i];
        end
        last_c = cyc;
        @(negedge clk);
        MOSI = 1'b1;
    endtask

    // Returns T, the edge that samples the end bit.
    task automatic send_cmd(input logic [5:0] cmd, input logic [31:0] arg, input logic crc_x,
                            input logic end_bit, output int t);
        logic [39:0] head;
        logic [47:0] frame;
        int          c;
        head  = {2'b01, cmd, arg};
        frame = {head, crc7_of(head) ^ {6'd0, crc_x}, end_bit};
        send_bits(88'(frame), 48, c);
        t = c + 1;
    endtask

    task automatic bd_write(input logic [ADDR_W-1:0] a, input logic [63:0] d);
        @(negedge clk);
        bd_we    = 1'b1;
        bd_addr  = a;
        bd_wdata = d;
        @(negedge clk);
        bd_we = 1'b0;
        check("bd_load", bd_rdata, d);
    endtask

    task automatic exp_read(input int t, input logic [63:0] d);
        push(t + 1,   8,  88'(8'hFF),       "rd_r1_gap");
        push(t + 9,   8,  88'(8'h00),       "rd_r1");
        push(t + 17,  8,  88'(8'hFF),       "rd_gap");
        push(t + 25,  8,  88'(8'hFE),       "rd_token");
        push(t + 33,  64, 88'(d),           "rd_data");
        push(t + 97,  16, 88'(crc16_of(d)), "rd_crc");
        push(t + 113, 8,  88'(8'hFF),       "rd_idle");
    endtask

    task automatic cmd_err(input logic [5:0] cmd, input logic [31:0] arg, input logic crc_x,
                           input logic end_bit, input logic [7:0] r1, input string name);
        int t;
        send_cmd(cmd, arg, crc_x, end_bit, t);
        push(t + 1,  8,  88'(8'hFF),     {name, "_gap"});
        push(t + 9,  8,  88'(r1),        {name, "_r1"});
        push(t + 17, 24, 88'(24'hFFFFFF), {name, "_no_token"});
        wait_until(t + 42);
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [63:0] d, input logic flip,
                            input logic [63:0] old);
        int          t;
        int          c;
        int          w;
        logic [15:0] crc;
        bd_addr = a;
        send_cmd(CMD24(), 32'(a), 1'b0, 1'b1, t);
        push(t + 1, 8, 88'(8'hFF), "wr_r1_gap");
        push(t + 9, 8, 88'(8'h00), "wr_r1");
        wait_until(t + 17);
        crc = crc16_of(d) ^ {15'd0, flip};
        send_bits({8'hFE, d, crc}, 88, c);
        w = c + 1;
        check("wr_mem_before", bd_rdata, old);
        push(w + 1, 8, 88'(8'hFF), "wr_dresp_gap");
        if (!flip) begin
            push(w + 9,  8,  88'(8'h05),  "wr_dresp_ok");
            push(w + 17, 16, 88'(16'h0),  "wr_busy");
        end else begin
            push(w + 9,  8,  88'(8'h0B),  "wr_dresp_crc");
            push(w + 17, 16, 88'(16'hFFFF), "wr_no_busy");
        end
        push(w + 33, 8, 88'(8'hFF), "wr_idle");
        @(negedge clk);
        check("wr_mem_after", bd_rdata, flip ? old : d);
        wait_until(w + 42);
    endtask

    function automatic logic [5:0] CMD24();
        return 6'd24;
    endfunction

    // Monitor: collects each expected MISO window and compares it as one value.
    initial begin : monitor
        exp_t        cur;
        logic [87:0] got;
        int          n;
        got = '0;
        n   = 0;
        forever begin
            @(negedge clk);
            if (!mon_busy && exp_q.size() > 0) begin
                if (exp_q[0].cyc < cyc) begin
                    cur = exp_q.pop_front();
                    checks++;
                    errors++;
                    $display("FAIL %s: window at cycle %0d missed (now %0d)", cur.name, cur.cyc, cyc);
                end else if (exp_q[0].cyc == cyc) begin
                    cur      = exp_q.pop_front();
                    mon_busy = 1'b1;
                    got      = '0;
                    n        = 0;
                end
            end
            if (mon_busy) begin
                got = {got[86:0], MISO};
                n++;
                if (n == cur.nbits) begin
                    mon_busy = 1'b0;
                    checks++;
                    if (got !== cur.val) begin
                        errors++;
                        $display("FAIL %s: MISO got %h expected %h (window at cycle %0d)",
                                 cur.name, got, cur.val, cur.cyc);
                    end
                end
            end
        end
    end

    initial begin : stimulus
        int          t;
        logic [63:0] d5;
        logic [63:0] d9_init;
        logic [63:0] d9;
        d5      = 64'h0123_4567_89AB_CDEF;
        d9_init = 64'h1111_2222_3333_4444;
        d9      = 64'hDEAD_BEEF_CAFE_F00D;

        repeat (3) @(negedge clk);
        check("rst_miso", 64'(MISO), 64'd1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        bd_write(6'd5, d5);
        bd_write(6'd9, d9_init);

        send_cmd(6'd17, 32'd5, 1'b0, 1'b1, t);
        exp_read(t, d5);
        wait_until(t + 122);

        do_write(6'd9, d9, 1'b0, d9_init);
        do_write(6'd9, 64'hFFFF_0000_1234_5678, 1'b1, d9);

        cmd_err(6'd17, 32'd5,          1'b1, 1'b1, 8'h08, "crc7_bad");
        cmd_err(6'd12, 32'd0,          1'b0, 1'b1, 8'h04, "illegal_cmd");
        cmd_err(6'd17, 32'h0000_0040,  1'b0, 1'b1, 8'h40, "addr_range");
        cmd_err(6'd24, 32'h0000_0100,  1'b0, 1'b1, 8'h40, "wr_addr_range");
        cmd_err(6'd17, 32'd5,          1'b0, 1'b0, 8'h01, "end_bit");
        cmd_err(6'd12, 32'h0000_0040,  1'b1, 1'b1, 8'h08, "prio_crc");

        // Reset while data bit 30 of the read block is on MISO.
        send_cmd(6'd17, 32'd5, 1'b0, 1'b1, t);
        push(t + 1,  8,  88'(8'hFF),    "rst_rd_r1_gap");
        push(t + 9,  8,  88'(8'h00),    "rst_rd_r1");
        push(t + 17, 8,  88'(8'hFF),    "rst_rd_gap");
        push(t + 25, 8,  88'(8'hFE),    "rst_rd_token");
        push(t + 33, 30, 88'(d5[63:34]), "rst_rd_head");
        wait_until(t + 63);
        rst_n = 1'b0;
        #1;
        check("rst_mid_miso", 64'(MISO), 64'd1);
        repeat (2) @(negedge clk);
        check("rst_hold_miso", 64'(MISO), 64'd1);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        send_cmd(6'd17, 32'd5, 1'b0, 1'b1, t);
        exp_read(t, d5);
        wait_until(t + 122);

        bd_addr = 6'd9;
        @(negedge clk);
        check("mem9_final", bd_rdata, d9);

        for (int i = 0; i < 300 && (exp_q.size() != 0 || mon_busy); i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || mon_busy) begin
            errors++;
            $display("FAIL drain: %0d windows still pending", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
